// File: rtl/fifo_serial_tx.sv
// Serial transmitter that drains an 8-bit FIFO through its pop port.
// Each popped byte goes out as 1 start bit, 8 data bits LSB first, 1 stop bit.
module fifo_serial_tx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_pop,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {StIdle, StPop, StLoad, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            pop_q, pop_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            cnt_last;
   logic            req;
   logic [CntW-1:0] cnt_next;

   assign cnt_last = (cnt_q == CntLast);
   assign cnt_next = cnt_last ? '0 : cnt_q + CntW'(1);
   assign req      = enable & ~fifo_empty;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop_d   = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (req) begin
               state_d = StPop;
               pop_d   = 1'b1;
            end
         end
         StPop: state_d = StLoad;
         // fifo_dout is valid now: one cycle after the pop pulse
         StLoad: begin
            shift_d = fifo_dout;
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = StStart;
         end
         StStart: begin
            cnt_d = cnt_next;
            if (cnt_last) begin
               tx_d    = shift_q[0];
               idx_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            cnt_d = cnt_next;
            if (cnt_last) begin
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  idx_d   = idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            cnt_d = cnt_next;
            if (cnt_last) begin
               done_d = 1'b1;
               if (req) begin
                  state_d = StPop;
                  pop_d   = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
         pop_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         pop_q   <= pop_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign fifo_pop   = pop_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench for fifo_serial_tx: a queue-based FIFO model feeds the DUT and
// a line decoder checks every frame against the bytes expected in order.
module tb_fifo_serial_tx;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       clk_run = 1'b1;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_dout = 8'h00;
   logic       fifo_pop, tx, busy, frame_done;

   logic [7:0] fq[$];     // FIFO contents
   logic [7:0] pend[$];   // bytes written by stimulus, enter the FIFO at next edge
   logic [7:0] exp_q[$];  // bytes expected on the line, in order
   int         gap_q[$];  // idle-high cycles seen before each start bit

   int n_cmp = 0;
   int n_err = 0;
   int pop_cnt = 0;

   fifo_serial_tx #(.CLKS_PER_BIT(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_pop  (fifo_pop),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   initial forever begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // FIFO model: one-cycle read latency, flag reflects contents after the pop
   always @(posedge clk) begin
      if (fifo_pop && fq.size() > 0) fifo_dout <= fq.pop_front();
      while (pend.size() > 0) fq.push_back(pend.pop_front());
      fifo_empty <= (fq.size() == 0);
   end

   // Line monitor: decodes frames, checks shape, latency and frame_done timing
   logic [7:0] rx;
   logic       cur, bad, stop_bit, tx_prev, pop_prev;
   bit         in_frame;
   int         fc, hi_run, since_pop;
   initial begin
      in_frame = 0; tx_prev = 1'b1; pop_prev = 1'b0; hi_run = 0; since_pop = 1000;
      rx = '0; cur = 1'b1; bad = 1'b0; stop_bit = 1'b0; fc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_frame = 0; tx_prev = 1'b1; pop_prev = 1'b0; hi_run = 0;
         end else begin
            if (fifo_pop) begin
               chk("pop_single_cycle", {31'd0, pop_prev}, 0);
               pop_cnt++;
               since_pop = 0;
            end else if (since_pop < 1000) begin
               since_pop++;
            end
            pop_prev = fifo_pop;
            if (!in_frame && tx_prev && !tx) begin
               in_frame = 1; fc = 0; rx = '0; bad = 1'b0; stop_bit = 1'b0;
               gap_q.push_back(hi_run);
               chk("start_latency", since_pop, 2);
            end else if (in_frame) begin
               fc++;
            end
            if (in_frame) begin
               if (fc < 10 * N) begin
                  if (fc % N == 0) begin
                     cur = tx;
                     if (fc / N >= 1 && fc / N <= 8) rx[fc/N-1] = tx;
                     if (fc / N == 9) stop_bit = tx;
                  end else if (tx !== cur) begin
                     bad = 1'b1;
                  end
                  if (frame_done !== 1'b0) bad = 1'b1;
               end else begin
                  chk("frame_done_pulse", {31'd0, frame_done}, 1);
                  chk("frame_clean", {30'd0, bad, stop_bit}, 1);
                  if (exp_q.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL unexpected_frame: got %h expected none", rx);
                  end else begin
                     chk("frame_byte", rx, exp_q.pop_front());
                  end
                  in_frame = 0;
               end
            end
            hi_run  = tx ? hi_run + 1 : 0;
            tx_prev = tx;
         end
      end
   end

   task automatic push(input logic [7:0] b, input bit expect_tx);
      pend.push_back(b);
      if (expect_tx) exp_q.push_back(b);
   endtask

   task automatic wait_idle(input int lim);
      bit ok = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && pend.size() == 0) begin
            ok = 1;
            break;
         end
      end
      chk("wait_idle_in_time", {31'd0, ok}, 1);
   endtask

   task automatic wait_pops(input int target);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pop_cnt >= target) begin
            ok = 1;
            break;
         end
      end
      chk("pop_in_time", {31'd0, ok}, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bit seen;
      // Reset values
      #1 rst = 1'b1;
      #1;
      chk("rst_tx", {31'd0, tx}, 1);
      chk("rst_pop", {31'd0, fifo_pop}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, frame_done}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte
      enable = 1'b1;
      p0 = pop_cnt;
      push(8'h01, 1);
      wait_idle(200);
      chk("single_pops", pop_cnt - p0, 1);
      chk("single_busy", {31'd0, busy}, 0);

      // Back-to-back
      gap_q.delete();
      p0 = pop_cnt;
      push(8'h02, 1); push(8'h03, 1); push(8'hA5, 1);
      wait_idle(500);
      chk("b2b_pops", pop_cnt - p0, 3);
      chk("b2b_frames", gap_q.size(), 3);
      if (gap_q.size() == 3) begin
         chk("b2b_gap1", gap_q[1], N + 2);
         chk("b2b_gap2", gap_q[2], N + 2);
      end

      // Gating
      enable = 1'b0;
      p0 = pop_cnt;
      push(8'hFF, 1);
      repeat (20) @(negedge clk);
      chk("gate_no_pop", pop_cnt - p0, 0);
      chk("gate_tx_idle", {31'd0, tx}, 1);
      enable = 1'b1;
      push(8'h00, 1);
      wait_pops(p0 + 2);
      repeat (8) @(negedge clk);
      enable = 1'b0;
      push(8'h77, 1);
      p0 = pop_cnt;
      repeat (100) @(negedge clk);
      chk("gate_pop_stopped", pop_cnt - p0, 0);
      chk("gate_busy", {31'd0, busy}, 0);
      chk("gate_pending", exp_q.size(), 1);
      enable = 1'b1;
      wait_idle(200);

      // Empty FIFO
      p0 = pop_cnt;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifo_pop || busy) seen = 1;
      end
      chk("empty_no_activity", {31'd0, seen}, 0);
      chk("empty_pops", pop_cnt - p0, 0);

      // Randomized traffic with enable wobbling
      for (int k = 0; k < 24; k++) begin
         repeat ($urandom_range(0, 50)) begin
            @(negedge clk);
            enable = ($urandom_range(0, 4) != 0);
         end
         push(8'($urandom), 1);
      end
      enable = 1'b1;
      wait_idle(5000);
      chk("random_drained", fq.size(), 0);

      // Reset in the third data bit of 5A
      p0 = pop_cnt;
      push(8'h5A, 0);
      wait_pops(p0 + 1);
      repeat (2 + 3 * N + 1) @(negedge clk);
      chk("pre_rst_tx_low", {31'd0, tx}, 0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx", {31'd0, tx}, 1);
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_pop", {31'd0, fifo_pop}, 0);
      push(8'h3C, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_pop", {31'd0, fifo_pop}, 1);
      wait_idle(200);

      // Reset with the clock stopped mid-frame
      p0 = pop_cnt;
      push(8'h00, 0);
      wait_pops(p0 + 1);
      repeat (2 + N + 1) @(negedge clk);
      chk("stopclk_tx_low", {31'd0, tx}, 0);
      clk_run = 1'b0;
      #20 rst = 1'b1;
      #1;
      chk("stopclk_tx", {31'd0, tx}, 1);
      chk("stopclk_busy", {31'd0, busy}, 0);
      chk("stopclk_pop", {31'd0, fifo_pop}, 0);
      chk("stopclk_done", {31'd0, frame_done}, 0);
      #20 clk_run = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("final_tx", {31'd0, tx}, 1);
      chk("final_exp_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side consumer for the 8-bit push/pop FIFO. Whenever it is enabled and the FIFO is non-empty, it pops one byte and sends it on a single wire as an asynchronous serial frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits directly on the FIFO's pop port, so the FIFO acts as the transmit buffer between a byte producer and the serial line.

## Interface
Parameters:
- CLKS_PER_BIT, default 16, number of clk cycles per serial bit; legal range ≥ 2.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  permits starting a new frame; sampled only in IDLE and at stop-bit end.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO read data; valid the cycle after the cycle in which fifo_pop is high (one-cycle read latency).
- fifo_pop  output  1  registered pop request; one-cycle pulse per byte.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  registered one-cycle pulse at the end of each stop bit.

Block never drives push; the FIFO's push/pop-simultaneous case cannot originate here.

## Operation
- State machine: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: tx=1, fifo_pop=0. If enable=1 and fifo_empty=0 at the edge, go to POP with fifo_pop<=1.
- POP: lasts 1 cycle; fifo_pop is high during this cycle. Go to LOAD with fifo_pop<=0.
- LOAD: lasts 1 cycle. At the exiting edge, capture fifo_dout into the 8-bit shift register, set tx<=0, clear the baud counter, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles. Then tx<=shift[0], bit index<=0, go to DATA.
- DATA: each bit is held for CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the index. After bit 7 is held, tx<=1 and go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final edge, frame_done<=1 for one cycle. Then:
  - if enable=1 and fifo_empty=0, go to POP with fifo_pop<=1;
  - otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Width is clog2(CLKS_PER_BIT). Bit index is 3 bits.
- enable dropping mid-frame does not abort the frame. The current frame completes and no further pop occurs.
- fifo_empty is ignored outside IDLE and the STOP-end decision.
- Reset (async, any state):
  - Register values: state=IDLE, tx=1, fifo_pop=0, frame_done=0, busy=0, counters=0, shift register=0.
  - A byte already popped is lost. This is accepted behaviour.

## Timing
- Reset values: tx=1, fifo_pop=0, busy=0, frame_done=0.
- Edge E0 samples enable=1 and fifo_empty=0 in IDLE:
  - fifo_pop is high in cycle E0..E1.
  - fifo_dout is captured at E2.
  - tx falls at E2.
- tx transitions:
  - data bit k starts at E2+(k+1)·N, where N=CLKS_PER_BIT;
  - stop bit starts at E2+9N;
  - frame_done is high in cycle E2+10N..E2+10N+1.
- Latency from sampled request to start bit: 2 cycles. Frame length on the line: 10N cycles.
- Back-to-back frames: tx stays high for N+2 cycles between the last data bit and the next start bit (stop bit plus POP and LOAD).
- At most one fifo_pop pulse per frame. fifo_pop is never high for two consecutive cycles.
- busy rises with fifo_pop and falls at the edge entering IDLE.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- **Reset:** assert rst mid-run and with clk stopped → tx=1, fifo_pop=0, busy=0, frame_done=0 immediately, independent of clk.
- **Single byte:** FIFO holds 8'h01, enable=1 → one fifo_pop pulse; tx low 2 cycles after request; bits 1,0,0,0,0,0,0,0 for 4 cycles each; stop high 4 cycles; frame_done 42 cycles after the sampling edge; returns to IDLE with busy=0.
- **Back-to-back:** FIFO holds 8'h02, 8'h03, 8'hA5 → exactly 3 pops; line decodes 02, 03, A5; tx high exactly 6 cycles between the last data bit and the next start bit.
- **Gating:** FIFO holds 8'hFF with enable=0 → no pop, tx=1. Raise enable → frame FF is sent. Drop enable during DATA of a second byte 8'h00 → that frame completes; no further pop while enable=0.
- **Empty:** fifo_empty=1 with enable=1 for 100 cycles → fifo_pop never asserts, busy=0.
- **Reset mid-frame:** rst in the 3rd data bit of 8'h5A → tx=1 immediately. After release with 8'h3C queued → next pop 1 edge later; clean 3C frame; no glitch on tx.
